// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, fixed-latency instruction memory reader and IR with valid/ready handoff.
// Defining FETCH_PERF_EN adds perf_stall, a saturating count of HOLD cycles with instr_ready low.
module instr_fetch #(
    parameter int ADDR_W = 16,
    parameter int READ_LAT = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] memaddr,
    output logic              memread,
    input  logic [15:0]       memdata,
    output logic [15:0]       instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] pc_out,
`ifdef FETCH_PERF_EN
    output logic [15:0]       perf_stall,
`endif
    output logic [ADDR_W-1:0] pc_plus1
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;
    state_t state;
    logic [ADDR_W-1:0] pc;
    logic [2:0] cnt;
    assign memaddr = pc;
    // gated by reset so the strobe is low while reset is held, even though state is FETCH
    assign memread = (state == FETCH) && !reset;
    assign pc_plus1 = pc_out + 1'b1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc <= RESET_PC;
            cnt <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc_out <= RESET_PC;
        end else if (redirect) begin
            state <= FETCH;
            pc <= redirect_target;
            cnt <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    state <= WAIT;
                    cnt <= 3'd1;
                end
                WAIT: begin
                    if (cnt == 3'(READ_LAT)) begin
                        instruction <= memdata;
                        pc_out <= pc;
                        instr_valid <= 1'b1;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc <= pc + 1'b1;
                        instr_valid <= 1'b0;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_stall <= '0;
        else if (state == HOLD && !instr_ready && perf_stall != 16'hFFFF)
            perf_stall <= perf_stall + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch at READ_LAT=1, READ_LAT=3 and RESET_PC=16'hFFFF.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic instr_ready = 1'b0;
    logic redirect = 1'b0;
    logic [15:0] target = '0;
    logic [15:0] addr0, addr1, addr2, md0, md1, md2, ins0, ins1, ins2;
    logic [15:0] pco0, pco1, pco2, pp0, pp1, pp2;
    logic rd0, rd1, rd2, v0, v1, v2;
    logic [15:0] p0, p1a, p1b, p1c, p2;
`ifdef FETCH_PERF_EN
    logic [15:0] ps0, ps1, ps2;
`endif
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a);
        return a ^ 16'h5123;
    endfunction

    // memory models: data valid READ_LAT cycles after the strobe is sampled, DEAD otherwise
    always @(posedge clk) begin
        p0 <= rd0 ? word(addr0) : 16'hDEAD;
        p1a <= rd1 ? word(addr1) : 16'hDEAD;
        p1b <= p1a;
        p1c <= p1b;
        p2 <= rd2 ? word(addr2) : 16'hDEAD;
    end
    assign md0 = p0;
    assign md1 = p1c;
    assign md2 = p2;

    instr_fetch #(.ADDR_W(16), .READ_LAT(1), .RESET_PC(16'h0000)) u0 (
        .clk(clk), .reset(reset), .memaddr(addr0), .memread(rd0), .memdata(md0),
        .instruction(ins0), .instr_valid(v0), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_target(target), .pc_out(pco0),
`ifdef FETCH_PERF_EN
        .perf_stall(ps0),
`endif
        .pc_plus1(pp0));
    instr_fetch #(.ADDR_W(16), .READ_LAT(3), .RESET_PC(16'h0000)) u1 (
        .clk(clk), .reset(reset), .memaddr(addr1), .memread(rd1), .memdata(md1),
        .instruction(ins1), .instr_valid(v1), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_target(target), .pc_out(pco1),
`ifdef FETCH_PERF_EN
        .perf_stall(ps1),
`endif
        .pc_plus1(pp1));
    instr_fetch #(.ADDR_W(16), .READ_LAT(1), .RESET_PC(16'hFFFF)) u2 (
        .clk(clk), .reset(reset), .memaddr(addr2), .memread(rd2), .memdata(md2),
        .instruction(ins2), .instr_valid(v2), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_target(target), .pc_out(pco2),
`ifdef FETCH_PERF_EN
        .perf_stall(ps2),
`endif
        .pc_plus1(pp2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic restart();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // test 1: first fetch at READ_LAT=1
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(v0), 32'd0);
        check("rst_ins", 32'(ins0), 32'h0);
        check("rst_read", 32'(rd0), 32'd0);
        reset = 1'b0;
        #1;
        check("c0_read", 32'(rd0), 32'd1);
        check("c0_addr", 32'(addr0), 32'h0);
        check("c0_valid", 32'(v0), 32'd0);
        @(negedge clk);
        check("c1_read", 32'(rd0), 32'd0);
        check("c1_valid", 32'(v0), 32'd0);
        @(negedge clk);
        check("c2_valid", 32'(v0), 32'd1);
        check("c2_ins", 32'(ins0), 32'h5123);
        check("c2_pc", 32'(pco0), 32'h0);
        check("c2_pp1", 32'(pp0), 32'h1);
        // test 2: five stalled HOLD cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(v0), 32'd1);
            check("hold_ins", 32'(ins0), 32'h5123);
            check("hold_pc", 32'(pco0), 32'h0);
            check("hold_read", 32'(rd0), 32'd0);
        end
`ifdef FETCH_PERF_EN
        check("perf_stall", 32'(ps0), 32'd5);
`endif
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("acc_addr", 32'(addr0), 32'h1);
        check("acc_read", 32'(rd0), 32'd1);
        check("acc_valid", 32'(v0), 32'd0);
        repeat (2) @(negedge clk);
        check("i1_ins", 32'(ins0), 32'h5122);
        check("i1_pc", 32'(pco0), 32'h1);
        // test 4: redirect and accept together, redirect wins
        instr_ready = 1'b1;
        redirect = 1'b1;
        target = 16'h0010;
        @(negedge clk);
        instr_ready = 1'b0;
        redirect = 1'b0;
        check("rda_addr", 32'(addr0), 32'h10);
        check("rda_read", 32'(rd0), 32'd1);
        check("rda_valid", 32'(v0), 32'd0);
`ifdef FETCH_PERF_EN
        check("perf_hold", 32'(ps0), 32'd5);
`endif
        repeat (2) @(negedge clk);
        check("rda_ins", 32'(ins0), 32'h5133);
        check("rda_pc", 32'(pco0), 32'h10);
        check("rda_pp1", 32'(pp0), 32'h11);
        // test 3: redirect during WAIT at READ_LAT=3
        restart();
        check("l3_addr0", 32'(addr1), 32'h0);
        @(negedge clk);
        check("l3_wait_read", 32'(rd1), 32'd0);
        redirect = 1'b1;
        target = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        check("l3_rd_addr", 32'(addr1), 32'h40);
        check("l3_rd_read", 32'(rd1), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("l3_not_valid", 32'(v1), 32'd0);
            check("l3_ins_clear", 32'(ins1), 32'h0);
        end
        @(negedge clk);
        check("l3_valid", 32'(v1), 32'd1);
        check("l3_ins", 32'(ins1), 32'h5163);
        check("l3_pc", 32'(pco1), 32'h40);
        // test 5: wrap from RESET_PC=16'hFFFF
        restart();
        check("w_addr0", 32'(addr2), 32'hFFFF);
        check("w_read0", 32'(rd2), 32'd1);
        repeat (2) @(negedge clk);
        check("w_valid", 32'(v2), 32'd1);
        check("w_ins", 32'(ins2), 32'hAEDC);
        check("w_pc", 32'(pco2), 32'hFFFF);
        check("w_pp1", 32'(pp2), 32'h0);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("w_next_addr", 32'(addr2), 32'h0);
        // test 6: asynchronous reset during WAIT
        restart();
        redirect = 1'b1;
        target = 16'h0020;
        @(negedge clk);
        redirect = 1'b0;
        check("ar_addr", 32'(addr0), 32'h20);
        @(negedge clk);
        check("ar_wait_read", 32'(rd0), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", 32'(v0), 32'd0);
        check("ar_memaddr", 32'(addr0), 32'h0);
        check("ar_read", 32'(rd0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ar_restart_addr", 32'(addr0), 32'h0);
        check("ar_restart_read", 32'(rd0), 32'd1);
        repeat (2) @(negedge clk);
        check("ar_ins", 32'(ins0), 32'h5123);
        check("ar_pc", 32'(pco0), 32'h0);
        check("ar_valid_end", 32'(v0), 32'd1);
`ifdef FETCH_PERF_EN
        check("ar_perf", 32'(ps0), 32'd0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
